// File: rtl/instr_controller.sv
// Moore controller that decodes a 16-bit instruction and sequences the
// register file, A/B/C pipeline registers and status register of the datapath.
module instr_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] ir,
    output logic        w,
    output logic [1:0]  vsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    localparam logic [2:0] S_WAIT    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_WRIMM   = 3'd2;
    localparam logic [2:0] S_GETA    = 3'd3;
    localparam logic [2:0] S_GETB    = 3'd4;
    localparam logic [2:0] S_COMPUTE = 3'd5;
    localparam logic [2:0] S_WRREG   = 3'd6;

    logic [2:0] state;
    logic [2:0] next_state;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_WAIT;
        case (state)
            S_WAIT:    next_state = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (is_mov_imm) begin
                    next_state = S_WRIMM;
                end else if (is_mov_reg || is_mvn) begin
                    next_state = S_GETB;
                end else if (is_alu) begin
                    next_state = S_GETA;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_WRIMM:   next_state = S_WAIT;
            S_GETA:    next_state = S_GETB;
            S_GETB:    next_state = S_COMPUTE;
            S_COMPUTE: next_state = is_cmp ? S_WAIT : S_WRREG;
            S_WRREG:   next_state = S_WAIT;
            default:   next_state = S_WAIT;
        endcase
    end

    // Strobes depend on state only; reset masks every write/load so a cycle
    // interrupted by reset never commits anything.
    always_comb begin
        w        = 1'b0;
        vsel     = 2'b00;
        writenum = 3'd0;
        readnum  = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state)
            S_WAIT:  w = 1'b1;
            S_WRIMM: begin
                vsel     = 2'b10;
                writenum = rn;
                write    = 1'b1;
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_COMPUTE: begin
                shift = sh;
                asel  = is_mov_reg || is_mvn;
                ALUop = is_mov_reg ? 2'b00 : op;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            S_WRREG: begin
                writenum = rd;
                write    = 1'b1;
            end
            default: w = 1'b0;
        endcase
        if (reset) begin
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_controller.sv
// Self-checking bench for instr_controller: per-cycle strobe checks against a
// schedule built from the instruction rules, plus a small behavioural datapath.
module tb_instr_controller;

    typedef struct packed {
        logic       w;
        logic [1:0] vsel;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } outs_t;

    typedef struct {
        logic [15:0] ir;
        int          latency;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] ir;
    logic        w;
    logic [1:0]  vsel;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int    vectors     = 0;
    int    miscompares = 0;
    int    busy_cycles = 0;
    outs_t sched[$];

    always #5 clk = ~clk;

    instr_controller dut (
        .clk(clk), .reset(reset), .s(s), .ir(ir), .w(w), .vsel(vsel),
        .writenum(writenum), .readnum(readnum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(alu_op),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    // Minimal behavioural datapath so register-file effects can be observed.
    logic [15:0] regs [8];
    logic [15:0] ra = '0, rb = '0, rc = '0;
    logic        clear_regs = 1'b0;
    logic [15:0] shifted, ain, bin, alu_out;

    always_comb begin
        shifted = rb;
        case (shift)
            2'b01:   shifted = rb << 1;
            2'b10:   shifted = rb >> 1;
            2'b11:   shifted = {rb[15], rb[15:1]};
            default: shifted = rb;
        endcase
        ain = asel ? 16'd0 : ra;
        bin = bsel ? sximm5 : shifted;
        case (alu_op)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (clear_regs) begin
            for (int k = 0; k < 8; k++) regs[k] <= 16'd0;
        end else if (write) begin
            regs[writenum] <= (vsel == 2'b10) ? sximm8 : rc;
        end
        if (loada) ra <= regs[readnum];
        if (loadb) rb <= regs[readnum];
        if (loadc) rc <= alu_out;
    end

    function automatic outs_t idle_outs();
        outs_t o = '0;
        o.w = 1'b1;
        return o;
    endfunction

    // Expected per-cycle outputs from the sampling edge back to WAIT.
    task automatic build(input logic [15:0] i);
        outs_t      o;
        logic [1:0] op      = i[12:11];
        bit         mov_imm = (i[15:11] == 5'b11010);
        bit         mov_reg = (i[15:11] == 5'b11000);
        bit         alu     = (i[15:13] == 3'b101);
        bit         cmp     = alu && (op == 2'b01);
        bit         mvn     = alu && (op == 2'b11);
        sched.delete();
        o = '0;
        sched.push_back(o);
        if (mov_imm) begin
            o = '0; o.vsel = 2'b10; o.writenum = i[10:8]; o.write = 1'b1;
            sched.push_back(o);
        end
        if (alu && !mvn) begin
            o = '0; o.readnum = i[10:8]; o.loada = 1'b1;
            sched.push_back(o);
        end
        if (mov_reg || alu) begin
            o = '0; o.readnum = i[2:0]; o.loadb = 1'b1;
            sched.push_back(o);
            o = '0; o.shift = i[4:3]; o.asel = mov_reg || mvn;
            o.aluop = mov_reg ? 2'b00 : op; o.loadc = !cmp; o.loads = cmp;
            sched.push_back(o);
            if (!cmp) begin
                o = '0; o.writenum = i[7:5]; o.write = 1'b1;
                sched.push_back(o);
            end
        end
        sched.push_back(idle_outs());
    endtask

    task automatic checkOutput(input outs_t exp, input string name);
        outs_t       act;
        int          v8 = $signed(ir[7:0]);
        int          v5 = $signed(ir[4:0]);
        logic [15:0] e8 = v8[15:0];
        logic [15:0] e5 = v5[15:0];
        act = {w, vsel, writenum, readnum, write, loada, loadb, loadc, loads,
               asel, bsel, shift, alu_op};
        vectors++;
        if (act !== exp || sximm8 !== e8 || sximm5 !== e5) begin
            miscompares++;
            $display("[TB] FAIL %s ir=%h: got outs=%h sx8=%h sx5=%h, expected outs=%h sx8=%h sx5=%h",
                     name, ir, act, sximm8, sximm5, exp, e8, e5);
        end
    endtask

    task automatic checkValue(input int act, input int exp, input string name);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issues one instruction from a WAIT cycle and checks every cycle until WAIT.
    task automatic applyStimulus(input logic [15:0] i, input bit hold, input string name);
        build(i);
        ir = i;
        s  = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < sched.size(); k++) begin
            @(posedge clk);
            #1;
            if (k == 0) s = hold;
            if (!w) busy_cycles++;
            checkOutput(sched[k], name);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t      tbl[10];
        outs_t     o;
        logic [4:0] legal[6];
        logic [15:0] r;

        tbl[0] = '{16'hD007, 2, "mov_imm"};
        tbl[1] = '{16'hA148, 5, "add"};
        tbl[2] = '{16'hA900, 4, "cmp"};
        tbl[3] = '{16'hB860, 4, "mvn"};
        tbl[4] = '{16'hC01A, 4, "mov_reg"};
        tbl[5] = '{16'hB2F9, 5, "and"};
        tbl[6] = '{16'h0000, 1, "illegal_0"};
        tbl[7] = '{16'hE123, 1, "illegal_7"};
        tbl[8] = '{16'hD8FF, 1, "illegal_11011"};
        tbl[9] = '{16'hC8F0, 1, "illegal_11001"};
        legal = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

        reset = 1'b1;
        s     = 1'b1;
        ir    = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput(idle_outs(), "reset_hold");
        reset = 1'b0;
        s     = 1'b0;
        @(posedge clk);
        #1;
        checkOutput(idle_outs(), "after_reset");

        for (int t = 0; t < 10; t++) begin
            applyStimulus(tbl[t].ir, 1'b0, tbl[t].name);
            checkValue(busy_cycles, tbl[t].latency, {tbl[t].name, "_latency"});
        end

        $display("[TB] datapath integration");
        clear_regs = 1'b1;
        @(posedge clk);
        #1;
        clear_regs = 1'b0;
        applyStimulus(16'hD007, 1'b1, "int_mov_r0");
        applyStimulus(16'hD102, 1'b1, "int_mov_r1");
        applyStimulus(16'hA148, 1'b0, "int_add_r2");
        checkValue(int'(regs[0]), 7, "int_r0");
        checkValue(int'(regs[1]), 2, "int_r1");
        checkValue(int'(regs[2]), 16, "int_r2");

        $display("[TB] reset during GETB");
        ir = 16'hA148;
        s  = 1'b1;
        @(posedge clk); #1; s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        o = '0;
        checkOutput(o, "reset_in_getb_gated");
        @(posedge clk); #1;
        checkOutput(idle_outs(), "reset_in_getb_edge");
        reset = 1'b0;

        $display("[TB] reset during WRREG");
        ir = 16'hA061;
        s  = 1'b1;
        @(posedge clk); #1; s = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        o = '0;
        o.writenum = 3'd3;
        checkOutput(o, "reset_in_wrreg_gated");
        @(posedge clk); #1;
        checkOutput(idle_outs(), "reset_in_wrreg_edge");
        reset = 1'b0;
        checkValue(int'(regs[3]), 0, "reset_in_wrreg_no_write");

        $display("[TB] illegal with s held high");
        ir = 16'h0000;
        s  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checkOutput((k % 2 == 1) ? idle_outs() : outs_t'('0), "illegal_s_held");
        end
        s = 1'b0;
        @(posedge clk); #1;
        checkOutput(idle_outs(), "illegal_s_released");

        $display("[TB] randomized instructions");
        for (int n = 0; n < 40; n++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 4) != 0) r[15:11] = legal[$urandom_range(0, 5)];
            applyStimulus(r, 1'($urandom_range(0, 1)), "random");
        end
        s = 1'b0;
        @(posedge clk); #1;
        checkOutput(idle_outs(), "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
